// File: rtl/cipher_pkg.sv
// Shared types and constants for the additive byte cipher (encrypter_decrypter).
package cipher_pkg;

  localparam int unsigned DATA_W = 32'd8;

  typedef logic [DATA_W-1:0] byte_t;

  localparam byte_t DEFAULT_KEY = 8'h2B;
  localparam byte_t BYTE_ZERO   = 8'h00;
  localparam byte_t BYTE_ONE    = 8'h01;

  typedef enum logic {
    CIPHER_ENC = 1'b0,
    CIPHER_DEC = 1'b1
  } cipher_mode_e;

  // Sum/difference wraps naturally by truncation to DATA_W bits.
  function automatic byte_t cipher_apply(input cipher_mode_e mode, input byte_t data, input byte_t key);
    byte_t res;
    case (mode)
      CIPHER_ENC: res = data + key;
      CIPHER_DEC: res = data - key;
      default:    res = data;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/encrypter_decrypter_if.sv
// Key and lane handshake bundle for encrypter_decrypter.
interface encrypter_decrypter_if;
  import cipher_pkg::*;

  logic  key_load;
  byte_t key_in;
  logic  enc_valid_in;
  byte_t enc_data_in;
  logic  enc_valid_out;
  byte_t enc_data_out;
  logic  dec_valid_in;
  byte_t dec_data_in;
  logic  dec_valid_out;
  byte_t dec_data_out;
  byte_t key_out;

  modport master (
    output key_load, key_in, enc_valid_in, enc_data_in, dec_valid_in, dec_data_in,
    input  enc_valid_out, enc_data_out, dec_valid_out, dec_data_out, key_out
  );

  modport slave (
    input  key_load, key_in, enc_valid_in, enc_data_in, dec_valid_in, dec_data_in,
    output enc_valid_out, enc_data_out, dec_valid_out, dec_data_out, key_out
  );

endinterface

// File: rtl/cipher_lane.sv
// One registered cipher lane; CIPHER_ROLLING_KEY_EN adds a per-lane key offset counter.
module cipher_lane
  import cipher_pkg::*;
#(
  parameter cipher_mode_e MODE = CIPHER_ENC
) (
  input  logic  clock,
  input  logic  reset_n,
`ifdef CIPHER_ROLLING_KEY_EN
  input  logic  key_load,
`endif
  input  byte_t key,
  input  logic  valid_in,
  input  byte_t data_in,
  output logic  valid_out,
  output byte_t data_out
);

  logic  valid_d, valid_q;
  byte_t data_d, data_q;
  byte_t key_eff_s;

`ifdef CIPHER_ROLLING_KEY_EN
  byte_t offset_d, offset_q;

  // Offset advances per accepted byte; a key load wins over a same-cycle byte.
  always_comb begin
    offset_d = offset_q;
    if (key_load) begin
      offset_d = BYTE_ZERO;
    end else if (valid_in) begin
      offset_d = offset_q + BYTE_ONE;
    end else begin
      offset_d = offset_q;
    end
  end

  // Offset register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      offset_q <= BYTE_ZERO;
    end else begin
      offset_q <= offset_d;
    end
  end

  assign key_eff_s = key + offset_q;
`else
  assign key_eff_s = key;
`endif

  // Next output: new cipher word on valid, otherwise hold
  always_comb begin
    valid_d = valid_in;
    data_d  = data_q;
    if (valid_in) begin
      data_d = cipher_apply(MODE, data_in, key_eff_s);
    end else begin
      data_d = data_q;
    end
  end

  // Output registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      data_q  <= BYTE_ZERO;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_out = valid_q;
  assign data_out  = data_q;

endmodule

// File: rtl/encrypter_decrypter.sv
// Caesar (mod 256) encrypt/decrypt lanes sharing one key register.
// Optional rolling key offsets are enabled by defining CIPHER_ROLLING_KEY_EN.
module encrypter_decrypter
  import cipher_pkg::*;
(
  input logic                  clock,
  input logic                  reset_n,
  encrypter_decrypter_if.slave bus
);

  byte_t key_d, key_q;

  // Key update; same-cycle bytes still see key_q
  always_comb begin
    key_d = key_q;
    if (bus.key_load) begin
      key_d = bus.key_in;
    end else begin
      key_d = key_q;
    end
  end

  // Key register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      key_q <= DEFAULT_KEY;
    end else begin
      key_q <= key_d;
    end
  end

  assign bus.key_out = key_q;

  cipher_lane #(.MODE(CIPHER_ENC)) u_enc_lane (
    .clock     (clock),
    .reset_n   (reset_n),
`ifdef CIPHER_ROLLING_KEY_EN
    .key_load  (bus.key_load),
`endif
    .key       (key_q),
    .valid_in  (bus.enc_valid_in),
    .data_in   (bus.enc_data_in),
    .valid_out (bus.enc_valid_out),
    .data_out  (bus.enc_data_out)
  );

  cipher_lane #(.MODE(CIPHER_DEC)) u_dec_lane (
    .clock     (clock),
    .reset_n   (reset_n),
`ifdef CIPHER_ROLLING_KEY_EN
    .key_load  (bus.key_load),
`endif
    .key       (key_q),
    .valid_in  (bus.dec_valid_in),
    .data_in   (bus.dec_data_in),
    .valid_out (bus.dec_valid_out),
    .data_out  (bus.dec_data_out)
  );

endmodule

// File: tb/tb_encrypter_decrypter.sv
// Self-checking bench for encrypter_decrypter: directed cases plus randomized traffic
// against an integer-arithmetic reference model.
module tb_encrypter_decrypter;
  import cipher_pkg::*;

  logic clock   = 1'b0;
  logic reset_n = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  encrypter_decrypter_if ifc ();

  encrypter_decrypter dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (ifc.slave)
  );

  always #5 clock = ~clock;

  // Reference model state: key, per-lane byte index, and expected output registers.
  int   m_key;
  int   m_enc_off;
  int   m_dec_off;
  logic m_enc_v;
  logic m_dec_v;
  int   m_enc;
  int   m_dec;

  function automatic int wrap(input int v);
    return ((v % 256) + 256) % 256;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_key     = 43;
    m_enc_off = 0;
    m_dec_off = 0;
    m_enc_v   = 1'b0;
    m_dec_v   = 1'b0;
    m_enc     = 0;
    m_dec     = 0;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_enc_v"}, 32'(ifc.enc_valid_out), 32'(m_enc_v));
    chk({tag, "_enc_d"}, 32'(ifc.enc_data_out),  m_enc);
    chk({tag, "_dec_v"}, 32'(ifc.dec_valid_out), 32'(m_dec_v));
    chk({tag, "_dec_d"}, 32'(ifc.dec_data_out),  m_dec);
    chk({tag, "_key"},   32'(ifc.key_out),       m_key);
  endtask

  // One clock of stimulus; inputs change 1 time unit after the rising edge.
  task automatic step(input logic kl, input int ki, input logic ev, input int ed,
                      input logic dv, input int dd, input string tag);
    ifc.key_load     = kl;
    ifc.key_in       = byte_t'(ki);
    ifc.enc_valid_in = ev;
    ifc.enc_data_in  = byte_t'(ed);
    ifc.dec_valid_in = dv;
    ifc.dec_data_in  = byte_t'(dd);
    if (ev) m_enc = wrap(ed + m_key + m_enc_off);
    if (dv) m_dec = wrap(dd - m_key - m_dec_off);
    m_enc_v = ev;
    m_dec_v = dv;
    if (kl) begin
      m_key     = ki;
      m_enc_off = 0;
      m_dec_off = 0;
    end else begin
`ifdef CIPHER_ROLLING_KEY_EN
      if (ev) m_enc_off = wrap(m_enc_off + 1);
      if (dv) m_dec_off = wrap(m_dec_off + 1);
`endif
    end
    @(posedge clock);
    #1;
    check_outputs(tag);
  endtask

  initial begin
    int   y;
    int   x;
    int   prev_x;
    int   captured;
    logic have;

    ifc.key_load     = 1'b0;
    ifc.key_in       = 8'h00;
    ifc.enc_valid_in = 1'b0;
    ifc.enc_data_in  = 8'h00;
    ifc.dec_valid_in = 1'b0;
    ifc.dec_data_in  = 8'h00;

    // Reset state
    #1 reset_n = 1'b0;
    #2;
    model_reset();
    check_outputs("reset");
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset_n = 1'b1;

    // 1: 'A' -> 'l' and back
    step(1'b0, 0, 1'b1, 'h41, 1'b0, 0, "t1_enc");
    chk("t1_enc_lit", 32'(ifc.enc_data_out), 32'h6C);
    step(1'b0, 0, 1'b0, 0, 1'b1, 'h6C, "t1_dec");
    chk("t1_dec_lit", 32'(ifc.dec_data_out), 32'h41);

    // 2: "Hi" back-to-back, fed into the decrypt lane one cycle behind
    step(1'b1, 'h2B, 1'b0, 0, 1'b0, 0, "t2_rekey");
    step(1'b0, 0, 1'b1, 'h48, 1'b0, 0, "t2_h");
    y = int'(ifc.enc_data_out);
`ifndef CIPHER_ROLLING_KEY_EN
    chk("t2_h_lit", 32'(ifc.enc_data_out), 32'h73);
`endif
    step(1'b0, 0, 1'b1, 'h69, 1'b1, y, "t2_i");
`ifndef CIPHER_ROLLING_KEY_EN
    chk("t2_i_lit", 32'(ifc.enc_data_out), 32'h94);
`endif
    chk("t2_dec_h_lit", 32'(ifc.dec_data_out), 32'h48);
    y = int'(ifc.enc_data_out);
    step(1'b0, 0, 1'b0, 0, 1'b1, y, "t2_dec");
    chk("t2_dec_i_lit", 32'(ifc.dec_data_out), 32'h69);

    // 3: wrap-around in both directions
    step(1'b1, 'h2B, 1'b0, 0, 1'b0, 0, "t3_rekey");
    step(1'b0, 0, 1'b1, 'hF0, 1'b1, 'h10, "t3_wrap");
    chk("t3_enc_wrap_lit", 32'(ifc.enc_data_out), 32'h1B);
    chk("t3_dec_wrap_lit", 32'(ifc.dec_data_out), 32'hE5);
    step(1'b1, 'h2B, 1'b0, 0, 1'b0, 0, "t3_rekey2");
    step(1'b0, 0, 1'b1, 'hFF, 1'b0, 0, "t3_ff");
    y = int'(ifc.enc_data_out);
    step(1'b0, 0, 1'b0, 0, 1'b1, y, "t3_ff_back");
    chk("t3_ff_rt_lit", 32'(ifc.dec_data_out), 32'hFF);

    // 4: key load alongside a byte uses the old key
    step(1'b1, 'h2B, 1'b0, 0, 1'b0, 0, "t4_rekey");
    step(1'b1, 'h05, 1'b1, 'h41, 1'b0, 0, "t4_load");
    chk("t4_old_key_lit", 32'(ifc.enc_data_out), 32'h6C);
    step(1'b0, 0, 1'b1, 'h41, 1'b0, 0, "t4_new");
    chk("t4_new_key_lit", 32'(ifc.enc_data_out), 32'h46);
    chk("t4_key_out_lit", 32'(ifc.key_out), 32'h05);

    // key 0 is identity
    step(1'b1, 'h00, 1'b0, 0, 1'b0, 0, "k0_rekey");
    step(1'b0, 0, 1'b1, 'h5A, 1'b1, 'hA5, "k0_ident");

    // Round trip with a random key: dec lane replays the enc lane output
    step(1'b1, int'($urandom_range(0, 255)), 1'b0, 0, 1'b0, 0, "rt_rekey");
    have     = 1'b0;
    prev_x   = 0;
    captured = 0;
    for (int i = 0; i <= 40; i++) begin
      x = int'($urandom_range(0, 255));
      step(1'b0, 0, (i < 40), x, have, captured, "rt");
      if (have) chk("rt_roundtrip", 32'(ifc.dec_data_out), prev_x);
      captured = int'(ifc.enc_data_out);
      prev_x   = x;
      have     = (i < 40);
    end

    // Randomized traffic with occasional key loads
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 15) == 0), int'($urandom_range(0, 255)),
           1'($urandom_range(0, 1)), int'($urandom_range(0, 255)),
           1'($urandom_range(0, 1)), int'($urandom_range(0, 255)), "rand");
    end

    // 5: asynchronous reset while both lanes stream
    step(1'b1, 'h77, 1'b1, 'h12, 1'b1, 'h34, "t5_pre0");
    step(1'b0, 0, 1'b1, 'h56, 1'b1, 'h78, "t5_pre1");
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    check_outputs("t5_async");
    ifc.key_load     = 1'b0;
    ifc.enc_valid_in = 1'b0;
    ifc.dec_valid_in = 1'b0;
    @(posedge clock); #1;
    reset_n = 1'b1;
    chk("t5_key_lit", 32'(ifc.key_out), 32'h2B);
    step(1'b0, 0, 1'b0, 0, 1'b0, 0, "t5_idle");

`ifdef CIPHER_ROLLING_KEY_EN
    // 6: rolling offsets advance per byte and restart on key load
    step(1'b1, 'h2B, 1'b0, 0, 1'b0, 0, "t6_rekey");
    step(1'b0, 0, 1'b1, 'h41, 1'b0, 0, "t6_e0");
    chk("t6_e0_lit", 32'(ifc.enc_data_out), 32'h6C);
    y = int'(ifc.enc_data_out);
    step(1'b0, 0, 1'b1, 'h41, 1'b1, y, "t6_e1");
    chk("t6_e1_lit", 32'(ifc.enc_data_out), 32'h6D);
    chk("t6_d0_lit", 32'(ifc.dec_data_out), 32'h41);
    y = int'(ifc.enc_data_out);
    step(1'b0, 0, 1'b1, 'h41, 1'b1, y, "t6_e2");
    chk("t6_e2_lit", 32'(ifc.enc_data_out), 32'h6E);
    chk("t6_d1_lit", 32'(ifc.dec_data_out), 32'h41);
    y = int'(ifc.enc_data_out);
    step(1'b0, 0, 1'b0, 0, 1'b1, y, "t6_d2");
    chk("t6_d2_lit", 32'(ifc.dec_data_out), 32'h41);
    step(1'b1, 'h2B, 1'b0, 0, 1'b0, 0, "t6_reload");
    step(1'b0, 0, 1'b1, 'h41, 1'b0, 0, "t6_restart");
    chk("t6_restart_lit", 32'(ifc.enc_data_out), 32'h6C);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
